// File: rtl/aoi_sweep_ctrl_if.sv
// Handshake bundle between the sweep controller and the four_aoi under test.
// The master side drives start/abort and returns outG; the slave side is the controller.
interface aoi_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       outA, outB, outC, outD;
  logic       inG;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic [3:0] first_fail;
  logic       fail_valid;

  modport master (
    output start, abort, inG,
    input  outA, outB, outC, outD, busy, done, pass, err_cnt, first_fail, fail_valid
  );

  modport slave (
    input  start, abort, inG,
    output outA, outB, outC, outD, busy, done, pass, err_cnt, first_fail, fail_valid
  );
endinterface

// File: rtl/aoi_sweep_ctrl.sv
// Exhaustive 16-vector sweep of a four_aoi cell: apply, settle SETTLE cycles,
// compare outG against ~((A&B)|(C&D)), tally mismatches and latch the first one.
module aoi_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  aoi_sweep_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] out_q, out_d;
  logic [4:0] err_cnt_q, err_cnt_d;
  logic [3:0] first_fail_q, first_fail_d;
  logic       fail_valid_q, fail_valid_d;
  logic       expected;
  logic       mismatch;

  assign expected = ~((vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]));
  assign mismatch = (bus.inG != expected);

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    out_d        = out_q;
    err_cnt_d    = err_cnt_q;
    first_fail_d = first_fail_q;
    fail_valid_d = fail_valid_q;

    if (bus.abort) begin
      // abort wins over start and wipes every partial result
      state_d      = ST_IDLE;
      vec_d        = '0;
      cnt_d        = '0;
      out_d        = '0;
      err_cnt_d    = '0;
      first_fail_d = '0;
      fail_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d      = ST_APPLY;
            vec_d        = '0;
            out_d        = '0;
            err_cnt_d    = '0;
            first_fail_d = '0;
            fail_valid_d = 1'b0;
          end
        end
        ST_APPLY: begin
          state_d = ST_WAIT;
          cnt_d   = 4'(SETTLE - 1);
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_d = ST_CHECK;
          else               cnt_d   = cnt_q - 4'd1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_cnt_d = err_cnt_q + 5'd1;
            if (!fail_valid_q) begin
              first_fail_d = vec_q;
              fail_valid_d = 1'b1;
            end
          end
          if (vec_q == 4'hF) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_APPLY;
            vec_d   = vec_q + 4'd1;
            out_d   = vec_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      out_q        <= '0;
      err_cnt_q    <= '0;
      first_fail_q <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      err_cnt_q    <= err_cnt_d;
      first_fail_q <= first_fail_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign {bus.outA, bus.outB, bus.outC, bus.outD} = out_q;
  assign bus.busy       = (state_q == ST_APPLY) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.pass       = (state_q == ST_DONE) && (err_cnt_q == 5'd0);
  assign bus.err_cnt    = err_cnt_q;
  assign bus.first_fail = first_fail_q;
  assign bus.fail_valid = fail_valid_q;

endmodule

// File: tb/tb_aoi_sweep_ctrl.sv
// Scoreboard bench: each start pushes the model's expected sweep result; a monitor
// pops and compares whenever done rises. inG is served from a per-run response table.
module tb_aoi_sweep_ctrl;
  localparam int SETTLE  = 2;
  localparam int LATENCY = 16 * (SETTLE + 2) + 1;

  typedef struct {
    int err;
    int first;
    bit fv;
    bit pass;
    int start_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tbl;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          done_prev = 1'b0;
  exp_t        sb[$];

  aoi_sweep_ctrl_if bus ();

  aoi_sweep_ctrl #(.SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  wire [3:0] outs = {bus.outA, bus.outB, bus.outC, bus.outD};
  assign bus.inG = tbl[outs];

  function automatic bit aoi(input int v);
    logic [3:0] b;
    b = v[3:0];
    return !((b[3] && b[2]) || (b[1] && b[0]));
  endfunction

  function automatic logic [15:0] golden_tbl();
    logic [15:0] t;
    for (int v = 0; v < 16; v++) t[v] = aoi(v);
    return t;
  endfunction

  // Reference: count table entries disagreeing with the AOI truth table.
  function automatic exp_t model(input logic [15:0] t);
    exp_t e;
    e.err = 0; e.first = 0; e.fv = 1'b0; e.start_cyc = 0;
    for (int v = 0; v < 16; v++) begin
      if (t[v] != aoi(v)) begin
        e.err++;
        if (!e.fv) begin e.first = v; e.fv = 1'b1; end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the DUT result against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending sweep (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("err_cnt",    bus.err_cnt,    e.err);
        chk("first_fail", bus.first_fail, e.first);
        chk("fail_valid", bus.fail_valid, e.fv);
        chk("pass",       bus.pass,       e.pass);
        chk("last_vec",   outs,           15);
        // the start-sampling edge counts as edge 1
        chk("latency",    cyc - e.start_cyc + 1, LATENCY);
      end
    end
    done_prev = bus.done;
  end

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 300) begin @(negedge clk); n++; end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_outs(input int v);
    int n = 0;
    while (outs != v && n < 300) begin @(negedge clk); n++; end
    chk("reach_vec", outs, v);
  endtask

  task automatic run_sweep(input logic [15:0] t, input bit extra);
    exp_t e;
    tbl = t;
    e   = model(t);
    pulse_start();
    e.start_cyc = cyc;
    sb.push_back(e);
    chk("busy_after_start", bus.busy, 1);
    if (extra) begin
      repeat ($urandom_range(3, 30)) @(negedge clk);
      pulse_start();
      repeat ($urandom_range(1, 10)) @(negedge clk);
      pulse_start();
    end
    wait_done();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"},       outs,           0);
    chk({tag, "_busy"},       bus.busy,       0);
    chk({tag, "_done"},       bus.done,       0);
    chk({tag, "_pass"},       bus.pass,       0);
    chk({tag, "_err_cnt"},    bus.err_cnt,    0);
    chk({tag, "_first_fail"}, bus.first_fail, 0);
    chk({tag, "_fail_valid"}, bus.fail_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tbl       = golden_tbl();
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset_busy", bus.busy, 0);

    run_sweep(golden_tbl(), 1'b0);
    run_sweep(16'hFFFF, 1'b0);
    repeat (3) @(negedge clk);
    chk("done_hold",    bus.done,    1);
    chk("err_cnt_hold", bus.err_cnt, 7);
    chk("pass_hold",    bus.pass,    0);
    run_sweep(golden_tbl(), 1'b1);
    run_sweep(16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) run_sweep(16'($urandom()), 1'b1);
    run_sweep(golden_tbl() ^ 16'h8000, 1'b0);

    // abort in the first WAIT cycle of vec=5
    tbl = 16'hFFFF;
    pulse_start();
    wait_outs(5);
    @(negedge clk);
    chk("pre_abort_busy",    bus.busy,    1);
    chk("pre_abort_err_cnt", bus.err_cnt, 1);
    bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    chk_all_zero("abort");
    repeat (2) @(negedge clk);
    chk("abort_stays_idle", bus.busy, 0);

    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_busy", bus.busy, 0);
    chk("start_abort_done", bus.done, 0);

    // asynchronous reset while in CHECK of vec=6
    tbl = 16'hFFFF;
    pulse_start();
    wait_outs(6);
    repeat (SETTLE + 1) @(negedge clk);
    chk("pre_reset_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_idle", bus.busy, 0);

    run_sweep(golden_tbl(), 1'b0);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/aoi_sweep_ctrl.md
AOI_SWEEP_CTRL -- requirements
Module: aoi_sweep_ctrl

Interface
REQ-001 Parameter: SETTLE, default 2, number of wait cycles between applying a vector and sampling outG; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level-sampled request to begin a sweep.
REQ-005 abort  input  1  level-sampled request to cancel a sweep.
REQ-006 outA, outB, outC, outD  output  1 each  drive inA..inD of the four_aoi under test; all four are registered.
REQ-007 inG  input  1  outG returned from the four_aoi under test.
REQ-008 busy  output  1  sweep in progress.
REQ-009 done  output  1  sweep complete; results valid.
REQ-010 pass  output  1  high only when done is high and err_cnt equals 0.
REQ-011 err_cnt  output  5  number of mismatching vectors, range 0..16.
REQ-012 first_fail  output  4  {A,B,C,D} of the first mismatching vector.
REQ-013 fail_valid  output  1  first_fail holds a captured vector.

Function
REQ-014 The block SHALL use five states: IDLE, APPLY, WAIT, CHECK and DONE.
REQ-015 The vector index vec[3:0] SHALL map to {outA,outB,outC,outD} = vec, so D toggles fastest; the sweep SHALL run vec 0 to 15 in ascending order.
REQ-016 Transition IDLE to APPLY SHALL occur when start=1 and abort=0; on that edge vec, err_cnt, fail_valid and first_fail SHALL be cleared.
REQ-017 Transition APPLY to WAIT SHALL occur unconditionally after 1 cycle; out* SHALL be updated to vec on entry to APPLY.
REQ-018 WAIT SHALL last exactly SETTLE cycles, counted by a 4-bit down-counter, then go to CHECK.
REQ-019 In CHECK, the block SHALL compute expected = ~((A&B)|(C&D)) from vec and compare it with inG.
  - On mismatch, err_cnt SHALL increment.
  - On a mismatch while fail_valid=0, first_fail SHALL be set to vec and fail_valid to 1.
REQ-020 From CHECK: if vec=15, the next state SHALL be DONE; otherwise vec SHALL increment and the next state SHALL be APPLY. vec SHALL never wrap past 15.
REQ-021 Each vector SHALL take SETTLE+2 cycles; done SHALL rise 16*(SETTLE+2)+1 edges after the start-sampling edge (65 for SETTLE=2).
REQ-022 busy SHALL be 1 in APPLY, WAIT and CHECK, and 0 otherwise; done SHALL be 1 only in DONE.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 start in DONE SHALL restart the sweep exactly as from IDLE (REQ-016).
REQ-025 abort=1 in any state SHALL force the next state to IDLE; on that edge out*, err_cnt, first_fail and fail_valid SHALL be cleared.
REQ-026 abort SHALL have priority over start on the same edge.
REQ-027 out* SHALL be held stable through WAIT and CHECK; inG SHALL be sampled only in CHECK.
REQ-028 In DONE, out* SHALL hold the last vector (4'b1111), and all results SHALL hold until start, abort or reset.

Reset
REQ-029 On rst_n=0, the block SHALL, asynchronously and regardless of clk:
  - enter IDLE;
  - clear vec and the wait counter;
  - drive outA..outD=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0 and fail_valid=0.
REQ-030 Reset asserted mid-sweep SHALL discard all partial results.
REQ-031 After rst_n rises, no sweep SHALL start until start is sampled high.

Verification
REQ-032 Golden AOI model on out*/inG, SETTLE=2, 1-cycle start pulse -> busy=1 next edge; done=1 and pass=1 exactly 65 edges after start; err_cnt=0, fail_valid=0.
REQ-033 inG stuck at 1 -> done with err_cnt=7, pass=0, first_fail=4'b0011, fail_valid=1.
REQ-034 inG stuck at 0 -> err_cnt=9, first_fail=4'b0000.
REQ-035 Golden model, abort during vec=5 WAIT -> next edge state IDLE: busy=0, done=0, out*=0, err_cnt=0.
REQ-036 Start and abort high together in IDLE -> remains IDLE.
REQ-037 Start pulses during busy -> no effect on timing or results.
REQ-038 rst_n low asynchronously mid-CHECK -> all outputs 0 immediately without a clock edge.
REQ-039 Restart from DONE after the stuck-at-1 run, with golden model -> err_cnt cleared, pass=1 after 65 edges.
